// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master) and an apb_slave_mem responder (slave).
interface apb_slave_mem_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB word-addressed memory responder with range/alignment error reporting.
// Optional wait states are built only when APB_SLAVE_WAIT_EN is defined.
module apb_slave_mem #(
  parameter int unsigned SLAVE_ID    = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic            clk,
  input logic            hreset,
  apb_slave_mem_if.slave bus
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [31:0] Span   = 32'(4 * DEPTH);
  localparam logic [1:0]  SelIdx = SLAVE_ID[1:0];

`ifdef APB_SLAVE_WAIT_EN
  localparam logic [3:0] CntInit = WAIT_CYCLES[3:0];
  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;
  logic [3:0] r_cnt;
`else
  typedef enum logic [0:0] {StIdle, StReady} state_e;
`endif

  state_e      r_state;
  logic [31:0] r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [31:0] r_prdata;
  logic        r_pready;
  logic        r_pslverr;
  logic [31:0] r_mem [DEPTH];

  logic          w_sel;
  logic [31:0]   w_addr;
  logic          w_write;
  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_err;
  logic [31:0]   w_rdata;

  // In IDLE decode straight off the bus so a zero-wait setup can load Prdata in one edge.
  always_comb begin
    w_sel   = bus.Pselx[SelIdx];
    w_addr  = (r_state == StIdle) ? bus.Paddr  : r_addr;
    w_write = (r_state == StIdle) ? bus.Pwrite : r_write;
    w_off   = w_addr - BASE_ADDR;
    w_idx   = w_off[AW+1:2];
    w_err   = (w_off >= Span) || (w_addr[1:0] != 2'b00);
    w_rdata = (!w_write && !w_err) ? r_mem[w_idx] : 32'h0;
  end

  always_ff @(posedge clk or posedge hreset) begin
    if (hreset) begin
      r_state   <= StIdle;
      r_addr    <= 32'h0;
      r_write   <= 1'b0;
      r_wdata   <= 32'h0;
      r_prdata  <= 32'h0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
      r_cnt     <= 4'd0;
`endif
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_sel && !bus.Penable) begin
            r_addr  <= bus.Paddr;
            r_write <= bus.Pwrite;
            r_wdata <= bus.Pwdata;
`ifdef APB_SLAVE_WAIT_EN
            r_cnt   <= CntInit;
            if (CntInit != 4'd0) begin
              r_state <= StWait;
            end else begin
              r_state   <= StReady;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_rdata;
            end
`else
            r_state   <= StReady;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= w_rdata;
`endif
          end
        end
`ifdef APB_SLAVE_WAIT_EN
        StWait: begin
          if (!w_sel) begin
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_state   <= StReady;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_rdata;
            end
          end
        end
`endif
        StReady: begin
          if (!w_sel) begin
            r_state   <= StIdle;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end else if (bus.Penable) begin
            if (r_write && !w_err) r_mem[w_idx] <= r_wdata;
            r_state   <= StIdle;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.Prdata  = r_prdata;
  assign bus.Pready  = r_pready;
  assign bus.Pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem (SLAVE_ID 0, DEPTH 16); adapts wait-state count to the build.
module tb_apb_slave_mem;
  logic clk = 1'b0;
  logic hreset;
  int   n_vec = 0;
  int   n_err = 0;

`ifdef APB_SLAVE_WAIT_EN
  localparam int ExpWait = 2;
`else
  localparam int ExpWait = 0;
`endif

  always #5 clk = ~clk;

  apb_slave_mem_if bus ();

  apb_slave_mem #(
    .SLAVE_ID   (0),
    .BASE_ADDR  (32'h8000_0000),
    .DEPTH      (16),
    .WAIT_CYCLES(2)
  ) dut (
    .clk   (clk),
    .hreset(hreset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [2:0] sel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                      output int waits, output logic ok);
    @(negedge clk);
    bus.Pselx = sel; bus.Penable = 1'b0; bus.Pwrite = wr; bus.Paddr = addr; bus.Pwdata = wdata;
    @(negedge clk);
    bus.Penable = 1'b1;
    waits = 0;
    while (bus.Pready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    ok    = (bus.Pready === 1'b1);
    rdata = bus.Prdata;
    err   = bus.Pslverr;
    @(negedge clk);
    bus.Pselx = 3'b000; bus.Penable = 1'b0;
  endtask

  task automatic rw(input string tag, input logic wr, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          wt;
    logic        ok;
    xfer(3'b001, wr, addr, wdata, rd, er, wt, ok);
    chk({tag, " ready"}, 32'(ok), 32'd1);
    chk({tag, " waits"}, 32'(wt), 32'(ExpWait));
    chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " slverr"}, 32'(er), 32'(exp_err));
    chk({tag, " ready_drop"}, 32'(bus.Pready), 32'd0);
  endtask

  initial begin
    hreset = 1'b1;
    bus.Pselx = 3'b000; bus.Penable = 1'b0; bus.Pwrite = 1'b0;
    bus.Paddr = 32'h0; bus.Pwdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst pready", 32'(bus.Pready), 32'd0);
    chk("rst pslverr", 32'(bus.Pslverr), 32'd0);
    chk("rst prdata", bus.Prdata, 32'h0);
    hreset = 1'b0;

    rw("rd0 after reset", 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    rw("wr4", 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0);
    rw("rd4", 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0);
    chk("prdata hold", bus.Prdata, 32'hDEAD_BEEF);
    rw("wr3c", 1'b1, 32'h8000_003C, 32'h1234_5678, 32'h0, 1'b0);
    rw("rd3c", 1'b0, 32'h8000_003C, 32'h0, 32'h1234_5678, 1'b0);

    // Error cases: out of range, misaligned, below base
    rw("wr40 oor", 1'b1, 32'h8000_0040, 32'hAAAA_5555, 32'h0, 1'b1);
    rw("rd0 after oor", 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    rw("wr2 misalign", 1'b1, 32'h8000_0002, 32'h1111_1111, 32'h0, 1'b1);
    rw("rd0 after misalign", 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b0);
    rw("rd4 after misalign", 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0);
    rw("rd below base", 1'b0, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1);

    // Transfer addressed to another slave must be ignored
    @(negedge clk);
    bus.Pselx = 3'b010; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h8000_0004; bus.Pwdata = 32'h0;
    @(negedge clk);
    bus.Penable = 1'b1;
    repeat (4) @(negedge clk);
    chk("other sel pready", 32'(bus.Pready), 32'd0);
    bus.Pselx = 3'b000; bus.Penable = 1'b0;
    rw("rd4 after other sel", 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Access phase with no setup
    @(negedge clk);
    bus.Pselx = 3'b001; bus.Penable = 1'b1; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h8000_0004; bus.Pwdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("no setup pready", 32'(bus.Pready), 32'd0);
    bus.Pselx = 3'b000; bus.Penable = 1'b0;
    rw("rd4 after no setup", 1'b0, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Abort: setup a write, then drop select before completing
    @(negedge clk);
    bus.Pselx = 3'b001; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h8000_0008; bus.Pwdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.Pselx = 3'b000;
    @(negedge clk);
    chk("abort pready", 32'(bus.Pready), 32'd0);
    chk("abort pslverr", 32'(bus.Pslverr), 32'd0);
    rw("rd8 after abort", 1'b0, 32'h8000_0008, 32'h0, 32'h0, 1'b0);

    // Reset in the middle of a write
    rw("wr8", 1'b1, 32'h8000_0008, 32'hCAFE_F00D, 32'h0, 1'b0);
    rw("rd8", 1'b0, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    bus.Pselx = 3'b001; bus.Penable = 1'b0; bus.Pwrite = 1'b1;
    bus.Paddr = 32'h8000_0008; bus.Pwdata = 32'h0BAD_F00D;
    @(negedge clk);
    bus.Penable = 1'b1;
    hreset = 1'b1;
    #1;
    chk("mid rst pready", 32'(bus.Pready), 32'd0);
    chk("mid rst pslverr", 32'(bus.Pslverr), 32'd0);
    chk("mid rst prdata", bus.Prdata, 32'h0);
    @(negedge clk);
    hreset = 1'b0;
    bus.Pselx = 3'b000; bus.Penable = 1'b0;
    rw("rd8 after rst", 1'b0, 32'h8000_0008, 32'h0, 32'h0, 1'b0);
    rw("rd4 after rst", 1'b0, 32'h8000_0004, 32'h0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, vectors %0d", n_vec);
    $fatal(1, "watchdog expired");
  end
endmodule
